mmcm_reset_sequencer: RTL and testbench
=======================================

Name: mmcm_reset_sequencer

Overview:
- Supervises an MMCM and generates staggered, lock-qualified resets for NUM_DOMAINS downstream clock domains.
- Sits in the FPGA top level, clocked by the free-running oscillator clock taken directly from the IBUFDS output, not the MMCM output.
- Drives the MMCM RST pin and monitors its LOCKED output.
- On lock loss it recovers automatically: re-resets the MMCM, waits for lock and stability, then releases the domain resets in order.

Parameters:
- NUM_DOMAINS, 4: number of downstream reset outputs (1..16).
- RST_HOLD_CYCLES, 16: cycles mmcm_rst is held high per MMCM reset.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before declaring timeout.
- LOCK_STABLE_CYCLES, 1024: consecutive locked cycles required before release.
- STAGGER_CYCLES, 8: spacing between successive domain releases (>=1).
- SYNC_STAGES, 2: synchroniser depth for locked_async (>=2).

Ports:
- clk  in  1  free-running oscillator clock.
- rst_n  in  1  synchronous, active-low reset.
- locked_async  in  1  MMCM LOCKED; asynchronous to clk.
- sw_reset_req  in  1  single-cycle request to restart the full sequence.
- mmcm_rst  out  1  MMCM RST; active high.
- domain_rst_n  out  NUM_DOMAINS  per-domain active-low resets.
- ready  out  1  high when all domains are released and lock is held.
- timeout_err  out  1  sticky; set on lock timeout.
- lock_loss_count  out  8  saturating count of lock losses after release began.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset: one clock; rst_n is synchronous and active-low, sampled on the rising edge of clk. While rst_n=0 the block sits in RESET_MMCM with:
  - mmcm_rst=1, domain_rst_n=0, ready=0, timeout_err=0, lock_loss_count=0.
  - counter=0 and synchroniser flops=0.
  - rst_n asserted mid-operation takes effect at the next edge, whatever the state.
- All outputs are registered. locked_sync is locked_async delayed through SYNC_STAGES flops.
- RESET_MMCM:
  - mmcm_rst=1; counter counts 0..RST_HOLD_CYCLES-1.
  - At terminal count: go to WAIT_LOCK, counter=0.
- WAIT_LOCK:
  - mmcm_rst=0.
  - locked_sync=1: go to STABLE, counter=0.
  - Otherwise, at counter==LOCK_TIMEOUT_CYCLES-1: set timeout_err and go to RESET_MMCM. Retries are unlimited.
- STABLE:
  - locked_sync=0: go to WAIT_LOCK, counter=0. This is not counted as a lock loss and does not reset the MMCM.
  - At counter==LOCK_STABLE_CYCLES-1 with locked_sync=1: go to RELEASE, counter=0.
- RELEASE:
  - domain_rst_n[i] is set at the edge where counter==i*STAGGER_CYCLES. Domain 0 is therefore released on the first RELEASE cycle.
  - After domain NUM_DOMAINS-1 is released: go to RUN. ready=1 from the cycle after the last release.
- RUN: holds until lock loss, sw_reset_req or rst_n.
- Lock loss (locked_sync=0) in RELEASE or RUN:
  - Next edge: domain_rst_n=0, ready=0, state=RESET_MMCM, counter=0.
  - lock_loss_count increments, saturating at 255.
- sw_reset_req=1 in any state other than RESET_MMCM:
  - Same transition as lock loss, but with no count increment.
  - In RESET_MMCM it restarts the hold counter.
- Simultaneous sw_reset_req and lock loss: a single transition; the count increments once.
- timeout_err clears only on rst_n.
- Counter width: clog2 of the largest of the four cycle parameters, plus 1. The counter never wraps; it is cleared on every state change.

Optional Feature:
- Macro MMCM_RST_SEQ_LOSS_CNT_EN.
- Defined: lock_loss_count is implemented as above.
- Undefined: the port is present but tied to 0, and no counter flops are inferred.

Decomposition:
- Package cvs_clk_pkg holds:
  - seq_state_e enum: RESET_MMCM=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
  - LOSS_CNT_W=8.
  - A max-of-four function used to size the counter.
- Sub-module bit_sync (parameter STAGES) provides the locked_async synchroniser, carrying the ASYNC_REG attribute. It is reused for other async status inputs.

Test Plan (NUM_DOMAINS=3, RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=2, SYNC_STAGES=2):
- Release rst_n with locked_async=0 -> mmcm_rst high 4 cycles, low 32 cycles; then timeout_err=1 and mmcm_rst high again; domain_rst_n stays 3'b000.
- locked_async rises and stays high -> STABLE 8 cycles; domain_rst_n goes 3'b001, 3'b011, 3'b111 at 2-cycle spacing; ready=1 one cycle later.
- locked_async low 3 cycles during STABLE at counter 5 -> state WAIT_LOCK; mmcm_rst stays 0; lock_loss_count=0; stable count restarts from 0.
- locked_async drops in RUN -> next edge after locked_sync falls: domain_rst_n=3'b000, ready=0, mmcm_rst=1, lock_loss_count=1. After 300 such losses -> count=255.
- sw_reset_req in RUN -> reset sequence replays and count is unchanged. sw_reset_req coincident with lock loss -> count increments by exactly 1.
- rst_n pulsed low for 1 cycle while domain_rst_n=3'b011 -> next edge: all outputs at reset values; timeout_err and count cleared.

Source files
------------

// File: rtl/cvs_clk_pkg.sv
// Shared types and helpers for the clock/reset supervision slice.
// Holds the sequencer state encoding, loss-count width and a sizing helper.
package cvs_clk_pkg;

  typedef enum logic [2:0] {
    RESET_MMCM = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RELEASE    = 3'd3,
    RUN        = 3'd4
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous status bit.
// Ports: clk, rst_n (sync, active-low), i_async in, o_sync out.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// MMCM supervisor: holds MMCM in reset, waits for stable lock, then releases
// NUM_DOMAINS active-low resets one by one; recovers on lock loss.
// Ports: clk, rst_n (sync active-low), locked_async, sw_reset_req in;
// mmcm_rst, domain_rst_n, ready, timeout_err, lock_loss_count, state_o out.
// Optional: define MMCM_RST_SEQ_LOSS_CNT_EN to implement lock_loss_count;
// otherwise that port is tied to zero.
module mmcm_reset_sequencer
  import cvs_clk_pkg::*;
#(
  parameter int NUM_DOMAINS         = 4,
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   locked_async,
  input  logic                   sw_reset_req,
  output logic                   mmcm_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic                   timeout_err,
  output logic [LOSS_CNT_W-1:0]  lock_loss_count,
  output logic [2:0]             state_o
);

  localparam int CNT_MAX = max4(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                LOCK_STABLE_CYCLES, STAGGER_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  =
    CNT_W'((NUM_DOMAINS - 1) * STAGGER_CYCLES);

  seq_state_e             r_state;
  seq_state_e             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_locked;
  logic                   w_timeout;
  logic [NUM_DOMAINS-1:0] w_dom_nxt;

  logic                   r_mmcm_rst;
  logic [NUM_DOMAINS-1:0] r_dom_rst_n;
  logic                   r_ready;
  logic                   r_timeout_err;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (locked_async),
    .o_sync  (w_locked)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    unique case (r_state)
      RESET_MMCM: begin
        if (sw_reset_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (sw_reset_req) begin
          w_state_nxt = RESET_MMCM;
          w_cnt_nxt   = '0;
        end else if (w_locked) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = RESET_MMCM;
          w_cnt_nxt   = '0;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE: begin
        // A dropout before release only restarts the lock wait;
        // the MMCM is not reset and no loss is counted.
        if (sw_reset_req) begin
          w_state_nxt = RESET_MMCM;
          w_cnt_nxt   = '0;
        end else if (!w_locked) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (sw_reset_req || !w_locked) begin
          w_state_nxt = RESET_MMCM;
          w_cnt_nxt   = '0;
        end else if (r_cnt == REL_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (sw_reset_req || !w_locked) begin
          w_state_nxt = RESET_MMCM;
        end
      end
      default: begin
        w_state_nxt = RESET_MMCM;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Domain releases are decoded from the next count so that bit i
  // rises together with the counter reaching i*STAGGER_CYCLES.
  always_comb begin
    w_dom_nxt = '0;
    if (w_state_nxt == RELEASE || w_state_nxt == RUN) begin
      w_dom_nxt = r_dom_rst_n;
      if (w_state_nxt == RELEASE) begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          if (w_cnt_nxt == CNT_W'(i * STAGGER_CYCLES)) begin
            w_dom_nxt[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RESET_MMCM;
      r_cnt         <= '0;
      r_mmcm_rst    <= 1'b1;
      r_dom_rst_n   <= '0;
      r_ready       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mmcm_rst    <= (w_state_nxt == RESET_MMCM);
      r_dom_rst_n   <= w_dom_nxt;
      r_ready       <= (w_state_nxt == RUN);
      r_timeout_err <= r_timeout_err | w_timeout;
    end
  end

`ifdef MMCM_RST_SEQ_LOSS_CNT_EN
  logic                  w_loss_evt;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // Loss only counts once domains have started to come out of reset.
  assign w_loss_evt = (r_state == RELEASE || r_state == RUN) && !w_locked;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign lock_loss_count = r_loss_cnt;
`else
  assign lock_loss_count = '0;
`endif

  assign mmcm_rst     = r_mmcm_rst;
  assign domain_rst_n = r_dom_rst_n;
  assign ready        = r_ready;
  assign timeout_err  = r_timeout_err;
  assign state_o      = r_state;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Directed bench for mmcm_reset_sequencer with small parameters.
// Expected values are hand-derived from the sequence timing.
module tb_mmcm_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked_async;
  logic       sw_reset_req;
  logic       mmcm_rst;
  logic [2:0] domain_rst_n;
  logic       ready;
  logic       timeout_err;
  logic [7:0] lock_loss_count;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int losses = 0;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd4;

  mmcm_reset_sequencer #(
    .NUM_DOMAINS         (3),
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .STAGGER_CYCLES      (2),
    .SYNC_STAGES         (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .locked_async    (locked_async),
    .sw_reset_req    (sw_reset_req),
    .mmcm_rst        (mmcm_rst),
    .domain_rst_n    (domain_rst_n),
    .ready           (ready),
    .timeout_err     (timeout_err),
    .lock_loss_count (lock_loss_count),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef MMCM_RST_SEQ_LOSS_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state_o !== s && n < 200) begin
      tick();
      n++;
    end
    if (state_o !== s) begin
      errors++;
      $display("FAIL %s wait: state %0d required %0d", tag, state_o, s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    locked_async = 1'b0;
    sw_reset_req = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({mmcm_rst, domain_rst_n, ready, timeout_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outs: got %b required 100000",
               {mmcm_rst, domain_rst_n, ready, timeout_err});
    end
    checks++;
    if (lock_loss_count !== 8'd0 || state_o !== S_RESET) begin
      errors++;
      $display("FAIL reset_cnt_state: cnt %0d st %0d required 0 0",
               lock_loss_count, state_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    int hi;
    int lo;
    logic dom_bad;
    hi = 0;
    lo = 0;
    dom_bad = 1'b0;
    while (mmcm_rst === 1'b1 && hi < 100) begin
      hi++;
      tick();
    end
    while (mmcm_rst === 1'b0 && lo < 100) begin
      if (domain_rst_n !== 3'b000) dom_bad = 1'b1;
      lo++;
      tick();
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL hold_len: got %0d required 4", hi);
    end
    checks++;
    if (lo != 32) begin
      errors++;
      $display("FAIL timeout_len: got %0d required 32", lo);
    end
    checks++;
    if (timeout_err !== 1'b1 || mmcm_rst !== 1'b1 || state_o !== S_RESET) begin
      errors++;
      $display("FAIL timeout_flag: to %b rst %b st %0d required 1 1 0",
               timeout_err, mmcm_rst, state_o);
    end
    checks++;
    if (dom_bad || domain_rst_n !== 3'b000) begin
      errors++;
      $display("FAIL timeout_dom: got %b required 000", domain_rst_n);
    end
  endtask

  task automatic test_stable_glitch();
    logic rst_seen;
    logic wait_seen;
    int n;
    rst_seen = 1'b0;
    wait_seen = 1'b0;
    locked_async = 1'b1;
    wait_state(S_STABLE, "stable1");
    repeat (5) tick();
    locked_async = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mmcm_rst !== 1'b0) rst_seen = 1'b1;
      if (state_o === S_WAIT) wait_seen = 1'b1;
    end
    locked_async = 1'b1;
    n = 0;
    while (state_o !== S_STABLE && n < 50) begin
      if (mmcm_rst !== 1'b0) rst_seen = 1'b1;
      if (state_o === S_WAIT) wait_seen = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (!wait_seen || state_o !== S_STABLE) begin
      errors++;
      $display("FAIL glitch_wait: seen %b st %0d required 1 2",
               wait_seen, state_o);
    end
    checks++;
    if (rst_seen) begin
      errors++;
      $display("FAIL glitch_mmcm: mmcm_rst 1 required 0");
    end
    checks++;
    if (lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL glitch_cnt: got %0d required 0", lock_loss_count);
    end
  endtask

  task automatic test_release();
    logic [2:0] exp_dom [6];
    logic       exp_rdy [6];
    int n;
    exp_dom = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    n = 0;
    while (state_o === S_STABLE && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL stable_len: got %0d required 8", n);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (domain_rst_n !== exp_dom[i] || ready !== exp_rdy[i] ||
          mmcm_rst !== 1'b0) begin
        errors++;
        $display("FAIL release_%0d: dom %b rdy %b rst %b required %b %b 0",
                 i, domain_rst_n, ready, mmcm_rst, exp_dom[i], exp_rdy[i]);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_lock_loss();
    locked_async = 1'b0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b1 || domain_rst_n !== 3'b111) begin
      errors++;
      $display("FAIL loss_pre: rdy %b dom %b required 1 111",
               ready, domain_rst_n);
    end
    tick();
    losses++;
    checks++;
    if ({mmcm_rst, domain_rst_n, ready} !== 5'b10000 ||
        state_o !== S_RESET) begin
      errors++;
      $display("FAIL loss_outs: got %b st %0d required 10000 0",
               {mmcm_rst, domain_rst_n, ready}, state_o);
    end
    checks++;
    if (lock_loss_count !== exp_cnt(losses)) begin
      errors++;
      $display("FAIL loss_cnt1: got %0d required %0d",
               lock_loss_count, exp_cnt(losses));
    end
  endtask

  task automatic test_sw_reset();
    locked_async = 1'b1;
    wait_state(S_RUN, "sw_run1");
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checks++;
    if ({mmcm_rst, domain_rst_n, ready} !== 5'b10000 ||
        lock_loss_count !== exp_cnt(losses)) begin
      errors++;
      $display("FAIL sw_outs: got %b cnt %0d required 10000 %0d",
               {mmcm_rst, domain_rst_n, ready}, lock_loss_count,
               exp_cnt(losses));
    end
    wait_state(S_RUN, "sw_run2");
    checks++;
    if (domain_rst_n !== 3'b111 || ready !== 1'b1 ||
        lock_loss_count !== exp_cnt(losses)) begin
      errors++;
      $display("FAIL sw_replay: dom %b rdy %b cnt %0d required 111 1 %0d",
               domain_rst_n, ready, lock_loss_count, exp_cnt(losses));
    end
    locked_async = 1'b0;
    tick();
    tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    losses++;
    checks++;
    if (state_o !== S_RESET || lock_loss_count !== exp_cnt(losses)) begin
      errors++;
      $display("FAIL sw_coincident: st %0d cnt %0d required 0 %0d",
               state_o, lock_loss_count, exp_cnt(losses));
    end
  endtask

  task automatic test_saturate();
    while (losses < 300) begin
      locked_async = 1'b1;
      wait_state(S_RUN, "sat_run");
      locked_async = 1'b0;
      wait_state(S_RESET, "sat_reset");
      losses++;
    end
    checks++;
    if (lock_loss_count !== exp_cnt(losses)) begin
      errors++;
      $display("FAIL sat_cnt: got %0d required %0d",
               lock_loss_count, exp_cnt(losses));
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky_to: got %b required 1", timeout_err);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    n = 0;
    locked_async = 1'b1;
    while (domain_rst_n !== 3'b011 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (domain_rst_n !== 3'b011) begin
      errors++;
      $display("FAIL mid_reach: dom %b required 011", domain_rst_n);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({mmcm_rst, domain_rst_n, ready, timeout_err} !== 6'b100000 ||
        lock_loss_count !== 8'd0 || state_o !== S_RESET) begin
      errors++;
      $display("FAIL mid_rst: got %b cnt %0d st %0d required 100000 0 0",
               {mmcm_rst, domain_rst_n, ready, timeout_err},
               lock_loss_count, state_o);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_stable_glitch();
    test_release();
    test_lock_loss();
    test_sw_reset();
    test_saturate();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
